// File: rtl/axi3_to_axi4_bresp_merger.sv
// axi3_to_axi4_bresp_merger
// Write-response side of the AXI4-to-AXI3 burst splitter. Each AXI4 write
// burst is issued as one or more AXI3 sub-bursts; this block collects the
// AXI3 B responses of every sub-burst and returns one merged AXI4 B response.
// The address-side splitter pushes the sub-burst count of each transaction
// into a small tracking FIFO, in issue order.
module axi3_to_axi4_bresp_merger #(
    parameter int AXI4_Aw_len = 8,
    parameter int AXI3_Aw_len = 4,
    parameter int Queue_Addr  = 2
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic                             Split_Push,
    input  logic [AXI4_Aw_len-AXI3_Aw_len:0] Split_Num_Bursts,
    output logic                             Queue_Is_Full,
    output logic                             Queue_Is_Empty,
    input  logic [1:0]                       S_AXI_bresp,
    input  logic                             S_AXI_bvalid,
    output logic                             S_AXI_bready,
    output logic [1:0]                       M_AXI_bresp,
    output logic                             M_AXI_bvalid,
    input  logic                             M_AXI_bready
);

    localparam int CNT_W = AXI4_Aw_len - AXI3_Aw_len + 1;
    localparam int DEPTH = 2 ** Queue_Addr;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        RESPOND
    } state_t;

    state_t state, state_nxt;

    // Tracking FIFO
    logic [CNT_W-1:0]      mem [DEPTH];
    logic [Queue_Addr-1:0] wr_ptr, rd_ptr;
    logic [Queue_Addr:0]   occ;
    logic                  push_ok;
    logic                  pop;
    logic [CNT_W-1:0]      head_cnt;

    // Merge datapath
    logic [CNT_W-1:0] cnt;
    logic [1:0]       worst;
    logic             all_ex;
    logic             load;
    logic             s_hs;
    logic [1:0]       sub_sev;
    logic [1:0]       worst_nxt;
    logic             all_ex_nxt;
    logic [1:0]       final_resp;

    assign Queue_Is_Full  = (occ == (Queue_Addr + 1)'(DEPTH));
    assign Queue_Is_Empty = (occ == '0);
    assign push_ok        = Split_Push && !Queue_Is_Full;
    assign s_hs           = S_AXI_bvalid && S_AXI_bready;
    // A stored count of zero still means one sub-burst.
    assign head_cnt       = (mem[rd_ptr] == '0) ? CNT_W'(1) : mem[rd_ptr];

    // FIFO storage write.
    // NOTE: the storage array carries no reset; occupancy and pointers alone
    // decide which entries are valid, so clearing the data would add nothing.
    always_ff @(posedge ACLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= Split_Num_Bursts;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps occupancy.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + Queue_Addr'(1);
            if (pop)     rd_ptr <= rd_ptr + Queue_Addr'(1);
            case ({push_ok, pop})
                2'b10:   occ <= occ + (Queue_Addr + 1)'(1);
                2'b01:   occ <= occ - (Queue_Addr + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state and handshake outputs.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        S_AXI_bready = 1'b0;
        M_AXI_bvalid = 1'b0;
        load         = 1'b0;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!Queue_Is_Empty) begin
                    load      = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                S_AXI_bready = 1'b1;
                if (S_AXI_bvalid && (cnt == CNT_W'(1))) state_nxt = RESPOND;
            end
            RESPOND: begin
                M_AXI_bvalid = 1'b1;
                if (M_AXI_bready) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Merge of the incoming sub-response into the running worst / all-EXOKAY.
    always_comb begin
        sub_sev    = S_AXI_bresp[1] ? S_AXI_bresp : RESP_OKAY;
        worst_nxt  = (sub_sev > worst) ? sub_sev : worst;
        all_ex_nxt = all_ex && (S_AXI_bresp == RESP_EXOKAY);
        if (worst_nxt[1])    final_resp = worst_nxt;
        else if (all_ex_nxt) final_resp = RESP_EXOKAY;
        else                 final_resp = RESP_OKAY;
    end

    // Sub-burst counter, merge registers and the held merged response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt         <= '0;
            worst       <= RESP_OKAY;
            all_ex      <= 1'b0;
            M_AXI_bresp <= RESP_OKAY;
        end else if (load) begin
            cnt    <= head_cnt;
            worst  <= RESP_OKAY;
            all_ex <= 1'b1;
        end else if (s_hs) begin
            cnt    <= cnt - CNT_W'(1);
            worst  <= worst_nxt;
            all_ex <= all_ex_nxt;
            if (cnt == CNT_W'(1)) M_AXI_bresp <= final_resp;
        end
    end

endmodule

// File: tb/tb_axi3_to_axi4_bresp_merger.sv
// Self-checking bench for axi3_to_axi4_bresp_merger: a table of complete
// transactions plus hand-written queue-full, backpressure and reset sequences.
// Merged responses are checked against a scoreboard queue of expected values.
module tb_axi3_to_axi4_bresp_merger;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       Split_Push;
    logic [4:0] Split_Num_Bursts;
    logic       Queue_Is_Full;
    logic       Queue_Is_Empty;
    logic [1:0] S_AXI_bresp;
    logic       S_AXI_bvalid;
    logic       S_AXI_bready;
    logic [1:0] M_AXI_bresp;
    logic       M_AXI_bvalid;
    logic       M_AXI_bready;

    axi3_to_axi4_bresp_merger #(
        .AXI4_Aw_len(8),
        .AXI3_Aw_len(4),
        .Queue_Addr (2)
    ) dut (
        .ACLK            (ACLK),
        .ARESET          (ARESET),
        .Split_Push      (Split_Push),
        .Split_Num_Bursts(Split_Num_Bursts),
        .Queue_Is_Full   (Queue_Is_Full),
        .Queue_Is_Empty  (Queue_Is_Empty),
        .S_AXI_bresp     (S_AXI_bresp),
        .S_AXI_bvalid    (S_AXI_bvalid),
        .S_AXI_bready    (S_AXI_bready),
        .M_AXI_bresp     (M_AXI_bresp),
        .M_AXI_bvalid    (M_AXI_bvalid),
        .M_AXI_bready    (M_AXI_bready)
    );

    always #5 ACLK = ~ACLK;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_count  = 0;
    logic [1:0] exp_q [$];

    typedef struct {
        int          num;   // value pushed on Split_Num_Bursts
        logic [31:0] resp;  // sub-response i in bits [2i+1:2i]
        logic [1:0]  want;  // merged response
    } vec_t;

    vec_t vecs [12];

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Scoreboard: every accepted merged response is compared in order.
    always @(negedge ACLK) begin
        if (!ARESET && M_AXI_bvalid && M_AXI_bready) begin
            m_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_m_resp: got %0h expected no response", M_AXI_bresp);
            end else begin
                check("m_resp", 32'(M_AXI_bresp), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic push(int num);
        Split_Push       = 1'b1;
        Split_Num_Bursts = 5'(num);
        @(posedge ACLK); #1;
        Split_Push       = 1'b0;
    endtask

    // Offer one AXI3 response and return just after the edge it is taken on.
    task automatic send_resp(logic [1:0] r);
        bit hs = 1'b0;
        S_AXI_bvalid = 1'b1;
        S_AXI_bresp  = r;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge ACLK);
            hs = S_AXI_bready;
        end
        @(posedge ACLK); #1;
        S_AXI_bvalid = 1'b0;
        check("s_handshake", 32'(hs), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge ACLK);
        check("drain_left", exp_q.size(), 0);
        @(posedge ACLK); #1;
    endtask

    task automatic run_vec(vec_t v);
        int n = (v.num == 0) ? 1 : v.num;
        exp_q.push_back(v.want);
        push(v.num);
        for (int i = 0; i < n; i++) begin
            send_resp(v.resp[2*i +: 2]);
            if (i < n - 1) check("early_bvalid", 32'(M_AXI_bvalid), 32'd0);
            else           check("bvalid_latency", 32'(M_AXI_bvalid), 32'd1);
        end
        wait_drain();
        check("empty_after", 32'(Queue_Is_Empty), 32'd1);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_s_bready"}, 32'(S_AXI_bready),   32'd0);
        check({tag, "_m_bvalid"}, 32'(M_AXI_bvalid),   32'd0);
        check({tag, "_m_bresp"},  32'(M_AXI_bresp),    32'd0);
        check({tag, "_full"},     32'(Queue_Is_Full),  32'd0);
        check({tag, "_empty"},    32'(Queue_Is_Empty), 32'd1);
    endtask

    initial begin
        int m_before;

        vecs[0]  = '{1,  32'h0000_0000, 2'b00}; // single OKAY
        vecs[1]  = '{3,  32'h0000_0015, 2'b01}; // EX,EX,EX
        vecs[2]  = '{3,  32'h0000_0011, 2'b00}; // EX,OKAY,EX
        vecs[3]  = '{2,  32'h0000_000E, 2'b11}; // SLV,DEC
        vecs[4]  = '{16, 32'h0000_2000, 2'b10}; // 15 OKAY, SLVERR at position 7
        vecs[5]  = '{2,  32'h0000_000B, 2'b11}; // DEC,SLV
        vecs[6]  = '{4,  32'h0000_0095, 2'b10}; // EX,EX,EX,SLV
        vecs[7]  = '{1,  32'h0000_0001, 2'b01}; // single EX
        vecs[8]  = '{0,  32'h0000_0003, 2'b11}; // count 0 means one: DEC
        vecs[9]  = '{16, 32'h5555_5555, 2'b01}; // 16 EX
        vecs[10] = '{2,  32'h0000_000D, 2'b11}; // EX,DEC
        vecs[11] = '{16, 32'h1555_5555, 2'b00}; // 15 EX then OKAY last

        ARESET           = 1'b1;
        Split_Push       = 1'b0;
        Split_Num_Bursts = '0;
        S_AXI_bresp      = 2'b00;
        S_AXI_bvalid     = 1'b0;
        M_AXI_bready     = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check_reset_outputs("reset");
        ARESET = 1'b0;
        @(posedge ACLK); #1;

        // Table of complete transactions.
        for (int v = 0; v < 12; v++) run_vec(vecs[v]);

        // Queue full: four pushes, a fifth is dropped, then drain in order.
        m_before = m_count;
        exp_q.push_back(2'b01); push(2);
        exp_q.push_back(2'b10); push(2);
        exp_q.push_back(2'b11); push(2);
        exp_q.push_back(2'b00); push(2);
        check("full_set", 32'(Queue_Is_Full), 32'd1);
        check("full_not_empty", 32'(Queue_Is_Empty), 32'd0);
        push(1);
        check("full_after_drop", 32'(Queue_Is_Full), 32'd1);
        send_resp(2'b01); send_resp(2'b01);
        send_resp(2'b00); send_resp(2'b10);
        send_resp(2'b11); send_resp(2'b00);
        send_resp(2'b00); send_resp(2'b00);
        wait_drain();
        check("full_resp_count", m_count - m_before, 4);
        check("full_empty_after", 32'(Queue_Is_Empty), 32'd1);

        // Backpressure: hold RESPOND for 10 cycles with the next response waiting.
        M_AXI_bready = 1'b0;
        exp_q.push_back(2'b10); push(1);
        exp_q.push_back(2'b01); push(1);
        send_resp(2'b10);
        S_AXI_bvalid = 1'b1;
        S_AXI_bresp  = 2'b01;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            check("bp_s_bready", 32'(S_AXI_bready), 32'd0);
            check("bp_m_bvalid", 32'(M_AXI_bvalid), 32'd1);
            check("bp_m_bresp",  32'(M_AXI_bresp),  32'd2);
        end
        @(posedge ACLK); #1;
        M_AXI_bready = 1'b1;
        @(posedge ACLK); #1;
        check("bp_idle_bubble", 32'(S_AXI_bready), 32'd0);
        check("bp_idle_bvalid", 32'(M_AXI_bvalid), 32'd0);
        @(posedge ACLK); #1;
        check("bp_collect", 32'(S_AXI_bready), 32'd1);
        @(posedge ACLK); #1;
        S_AXI_bvalid = 1'b0;
        check("bp_next_latency", 32'(M_AXI_bvalid), 32'd1);
        wait_drain();

        // Reset in the middle of a collect: nothing may come out afterwards.
        m_before = m_count;
        push(4);
        send_resp(2'b00);
        send_resp(2'b00);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        check_reset_outputs("midreset");
        S_AXI_bvalid = 1'b1;
        S_AXI_bresp  = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("midreset_hold", 32'(S_AXI_bready), 32'd0);
        end
        @(posedge ACLK); #1;
        S_AXI_bvalid = 1'b0;
        check("midreset_no_resp", m_count - m_before, 0);

        // Normal operation resumes after the reset.
        run_vec(vecs[3]);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
